// File: rtl/product_accumulator.sv
// Sums COUNT sign-extended products into an ACC_WIDTH accumulator and presents
// each completed sum (with a sticky overflow flag) through a valid/ready handshake.
module product_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int COUNT     = 8
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic [WIDTH-1:0]             product_in,
    input  logic                         overflow_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic                         clear_in,
    output logic [ACC_WIDTH-1:0]         sum_out,
    output logic                         sum_valid_out,
    input  logic                         sum_ready_in,
    output logic                         overflow_out,
    output logic [$clog2(COUNT+1)-1:0]   count_out
);

    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   sum_reg, sum_next;
    logic [CW-1:0]          count_reg, count_next;
    logic                   ovf_reg, ovf_next;

    logic [ACC_WIDTH-1:0]   product_ext;
    logic [ACC_WIDTH-1:0]   sum_add;
    logic [CW-1:0]          count_inc;
    logic                   add_ovf;
    logic                   accept;

    // Sign extension written per bit so ACC_WIDTH == WIDTH needs no zero-width replication.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_sext
            if (gi < WIDTH) begin : g_copy
                assign product_ext[gi] = product_in[gi];
            end else begin : g_sign
                assign product_ext[gi] = product_in[WIDTH-1];
            end
        end
    endgenerate

    assign ready_out = (state_reg == ACCUM) && !clear_in;
    assign accept    = valid_in && ready_out;
    assign sum_add   = sum_reg + product_ext;
    assign count_inc = count_reg + CW'(1);
    // Signed overflow: operands agree in sign but the result does not.
    assign add_ovf   = (sum_reg[ACC_WIDTH-1] == product_ext[ACC_WIDTH-1]) &&
                       (sum_add[ACC_WIDTH-1] != sum_reg[ACC_WIDTH-1]);

    always_comb begin
        state_next = state_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (clear_in) begin
            state_next = ACCUM;
            sum_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        sum_next   = sum_add;
                        count_next = count_inc;
                        ovf_next   = ovf_reg | overflow_in | add_ovf;
                        if (count_inc == CW'(COUNT)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready_in) begin
                        state_next = ACCUM;
                        sum_next   = '0;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg <= ACCUM;
            sum_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign sum_out       = sum_reg;
    assign count_out     = count_reg;
    assign overflow_out  = ovf_reg;
    assign sum_valid_out = (state_reg == DONE);

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the product width in bits.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32, giving the accumulator width in bits; ACC_WIDTH >= WIDTH.
REQ-003 The block SHALL have parameter COUNT, default 8, giving the number of products summed per result; COUNT >= 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk_in  input  1  rising-edge clock.
REQ-005 reset_in  input  1  synchronous active-high reset.
REQ-006 product_in  input  WIDTH  two's-complement product from the upstream multiplicator.
REQ-007 overflow_in  input  1  upstream multiplicator overflow flag, qualified by valid_in.
REQ-008 valid_in  input  1  product_in/overflow_in valid.
REQ-009 ready_out  output  1  block accepts a beat this cycle.
REQ-010 clear_in  input  1  synchronous abort of the current accumulation.
REQ-011 sum_out  output  ACC_WIDTH  accumulated two's-complement sum.
REQ-012 sum_valid_out  output  1  sum_out/overflow_out/count_out hold a completed result.
REQ-013 sum_ready_in  input  1  downstream accepts the result.
REQ-014 overflow_out  output  1  sticky overflow for the current result.
REQ-015 count_out  output  clog2(COUNT+1)  beats accepted into the current result.

Function
REQ-016 The FSM SHALL have two states: ACCUM (collecting beats) and DONE (presenting the result).
REQ-017 ready_out SHALL be 1 exactly when state = ACCUM and clear_in = 0.
REQ-018 A beat SHALL be accepted on a rising edge where valid_in = 1 and ready_out = 1; no other cycle changes the sum.
REQ-019 On accept, the sum SHALL update to sum + sign_extend(product_in) modulo 2^ACC_WIDTH, and count_out SHALL increment by 1.
REQ-020 On accept, overflow_out SHALL be set when overflow_in = 1 or the signed addition overflows ACC_WIDTH; once set, it stays set until the result is consumed, cleared or reset.
REQ-021 When the accepted beat brings count_out to COUNT, the FSM SHALL move to DONE, with sum_valid_out = 1 in the next cycle and sum_out already including that beat (latency 1 cycle from final accept).
REQ-022 In DONE, sum_out, overflow_out and count_out SHALL hold stable, and ready_out SHALL be 0, until the handshake completes.
REQ-023 A DONE handshake (sum_valid_out = 1 and sum_ready_in = 1 on an edge) SHALL clear the sum, count and overflow to 0 and return the FSM to ACCUM; ready_out SHALL be 1 in the following cycle.
REQ-024 sum_ready_in SHALL be ignored in ACCUM.
REQ-025 clear_in = 1 on an edge, in either state, SHALL clear the sum, count and overflow to 0, deassert sum_valid_out and return to ACCUM.
REQ-026 clear_in SHALL take priority over a concurrent valid_in (the beat is not accepted) and over a concurrent sum_ready_in (the result is dropped, not consumed).
REQ-027 valid_in while ready_out = 0 SHALL have no effect; the upstream holds the beat.
REQ-028 When COUNT = 1, every accepted beat SHALL produce a result directly (ACCUM -> DONE).

Reset
REQ-029 reset_in = 1 on an edge SHALL set state = ACCUM, sum_out = 0, count_out = 0, overflow_out = 0, sum_valid_out = 0, and ready_out = 1 once reset_in = 0.
REQ-030 reset_in SHALL override all other inputs, including mid-accumulation and in DONE.

Verification (WIDTH=16, ACC_WIDTH=32, COUNT=4)
REQ-031 Products 3, -5, 100, 7 on consecutive cycles with valid_in = 1 -> sum_valid_out = 1 one cycle after the 4th accept, with sum_out = 105, count_out = 4, overflow_out = 0.
REQ-032 Result held with sum_ready_in = 0 for 5 cycles while valid_in = 1 -> ready_out = 0, sum_out is stable at 105, and no beats are accepted; sum_ready_in = 1 -> next cycle ready_out = 1 and sum_out = 0.
REQ-033 Overflow_in = 1 on the 2nd beat only -> overflow_out = 1 from the next cycle through to the result; the next result has overflow_out = 0.
REQ-034 ACC_WIDTH=16: 0x7FFF then 1, 0, 0 -> sum_out = 0x8000 and overflow_out = 1.
REQ-035 clear_in = 1 together with valid_in = 1 after 2 beats -> that beat is not accepted and count_out = 0; the next 4 beats of 1 give sum_out = 4.
REQ-036 reset_in = 1 while in DONE -> next cycle sum_valid_out = 0, sum_out = 0, count_out = 0, and ready_out = 1 after release.
